// File: rtl/event_monitor.sv
// Edge monitor: synchronizes Sig, timestamps rise/fall events and
// queues them in a small FIFO with saturating counters and overflow flag.
module event_monitor #(
    parameter int TS_W  = 16,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Sig,
    input  logic             Enable,
    output logic             EvValid,
    input  logic             EvReady,
    output logic [1:0]       EvKind,
    output logic [TS_W-1:0]  EvTime,
    output logic [CNT_W-1:0] RiseCount,
    output logic [CNT_W-1:0] FallCount,
    output logic             Overflow,
    input  logic             ClearOvf
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [TS_W-1:0]  TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] KIND_RISE = 2'b01;
    localparam logic [1:0] KIND_FALL = 2'b10;

    // Synchronizer, edge history and warm-up state
    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic [1:0]       r_warm;
    logic             r_primed;

    // Timestamp, counters, sticky overflow
    logic [TS_W-1:0]  r_time;
    logic [CNT_W-1:0] r_rise;
    logic [CNT_W-1:0] r_fall;
    logic             r_ovf;

    // Event FIFO storage and pointers (extra MSB tells full from empty)
    logic [1:0]       r_mem_kind [DEPTH];
    logic [TS_W-1:0]  r_mem_time [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    // Combinational control
    logic             w_rise;
    logic             w_fall;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_accept;
    logic             w_drop;
    logic [1:0]       w_kind;
    logic [AW-1:0]    w_widx;
    logic [AW-1:0]    w_ridx;

    assign w_widx  = r_wptr[AW-1:0];
    assign w_ridx  = r_rptr[AW-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);

    // Edge detection, push/pop and drop decisions
    always_comb begin
        w_rise   = 1'b0;
        w_fall   = 1'b0;
        w_kind   = KIND_RISE;
        w_rise   = r_primed & Enable & r_s2 & ~r_prev;
        w_fall   = r_primed & Enable & ~r_s2 & r_prev;
        w_push   = w_rise | w_fall;
        w_kind   = w_rise ? KIND_RISE : KIND_FALL;
        w_pop    = ~w_empty & EvReady;
        w_accept = w_push & (~w_full | w_pop);
        w_drop   = w_push & w_full & ~w_pop;
    end

    // Two-flop synchronizer plus previous-sample register.
    // Primed only rises once Prev holds a genuinely synchronized sample,
    // so a level held high through reset never looks like an edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_prev   <= 1'b0;
            r_warm   <= 2'b00;
            r_primed <= 1'b0;
        end else begin
            r_s1     <= Sig;
            r_s2     <= r_s1;
            r_prev   <= r_s2;
            r_warm   <= {r_warm[0], 1'b1};
            r_primed <= r_warm[1];
        end
    end

    // Free-running timestamp, wraps naturally
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_time <= '0;
        end else begin
            r_time <= r_time + TS_ONE;
        end
    end

    // Saturating rise/fall counters, updated even when the record is dropped
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            if (w_rise && (r_rise != {CNT_W{1'b1}})) begin
                r_rise <= r_rise + CNT_ONE;
            end
            if (w_fall && (r_fall != {CNT_W{1'b1}})) begin
                r_fall <= r_fall + CNT_ONE;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ClearOvf) begin
            r_ovf <= 1'b0;
        end
    end

    // FIFO pointers; reset empties the queue
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_mem_kind[w_widx] <= w_kind;
            r_mem_time[w_widx] <= r_time;
        end
    end

    assign EvValid   = ~w_empty;
    assign EvKind    = w_empty ? 2'b00 : r_mem_kind[w_ridx];
    assign EvTime    = w_empty ? '0 : r_mem_time[w_ridx];
    assign RiseCount = r_rise;
    assign FallCount = r_fall;
    assign Overflow  = r_ovf;

endmodule

// File: tb/tb_event_monitor.sv
// Directed bench for event_monitor: reset, latency, FIFO full/overflow,
// enable gating, counter saturation and timestamp wrap.
module tb_event_monitor;

    logic        Clk;
    logic        Reset;
    logic        Sig;
    logic        Enable;
    logic        EvValid;
    logic        EvReady;
    logic [1:0]  EvKind;
    logic [15:0] EvTime;
    logic [7:0]  RiseCount;
    logic [7:0]  FallCount;
    logic        Overflow;
    logic        ClearOvf;

    logic        s_rst;
    logic        s_sig;
    logic        s_en;
    logic        s_valid;
    logic        s_rdy;
    logic [1:0]  s_kind;
    logic [3:0]  s_time;
    logic [1:0]  s_rise;
    logic [1:0]  s_fall;
    logic        s_ovf;
    logic        s_clr;

    int n_cmp = 0;
    int n_err = 0;

    event_monitor #(.TS_W(16), .CNT_W(8), .DEPTH(4)) u_dut (
        .Clk(Clk), .Reset(Reset), .Sig(Sig), .Enable(Enable),
        .EvValid(EvValid), .EvReady(EvReady), .EvKind(EvKind),
        .EvTime(EvTime), .RiseCount(RiseCount), .FallCount(FallCount),
        .Overflow(Overflow), .ClearOvf(ClearOvf)
    );

    event_monitor #(.TS_W(4), .CNT_W(2), .DEPTH(4)) u_sat (
        .Clk(Clk), .Reset(s_rst), .Sig(s_sig), .Enable(s_en),
        .EvValid(s_valid), .EvReady(s_rdy), .EvKind(s_kind),
        .EvTime(s_time), .RiseCount(s_rise), .FallCount(s_fall),
        .Overflow(s_ovf), .ClearOvf(s_clr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  exp_kind [4];
    logic [15:0] exp_time [4];

    initial begin
        Reset = 1'b1; Sig = 1'b1; Enable = 1'b1;
        EvReady = 1'b1; ClearOvf = 1'b0;
        s_rst = 1'b1; s_sig = 1'b0; s_en = 1'b1;
        s_rdy = 1'b1; s_clr = 1'b0;

        // Reset state with Sig high
        cyc(2);
        chk("rst_valid", 32'(EvValid), 32'd0);
        chk("rst_kind", 32'(EvKind), 32'd0);
        chk("rst_time", 32'(EvTime), 32'd0);
        chk("rst_rise", 32'(RiseCount), 32'd0);
        chk("rst_fall", 32'(FallCount), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);

        // Sig held high through release: no event
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("idle_valid", 32'(EvValid), 32'd0);
        end
        chk("idle_rise", 32'(RiseCount), 32'd0);

        // Single rise, latency and timestamp
        Reset = 1'b1; Sig = 1'b0;
        cyc(2);
        Reset = 1'b0;
        cyc(4);
        Sig = 1'b1;
        cyc(2);
        chk("lat_nobypass", 32'(EvValid), 32'd0);
        cyc(1);
        chk("lat_valid", 32'(EvValid), 32'd1);
        chk("lat_kind", 32'(EvKind), 32'd1);
        chk("lat_time", 32'(EvTime), 32'd6);
        chk("lat_rise", 32'(RiseCount), 32'd1);
        cyc(1);
        chk("pop_valid", 32'(EvValid), 32'd0);
        chk("pop_kind0", 32'(EvKind), 32'd0);
        chk("pop_time0", 32'(EvTime), 32'd0);

        // Five edges with no consumer: fill and overflow
        Reset = 1'b1; Sig = 1'b0; EvReady = 1'b0;
        cyc(1);
        Reset = 1'b0;
        cyc(4);
        Sig = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(4);
            Sig = ~Sig;
        end
        cyc(4);
        chk("full_valid", 32'(EvValid), 32'd1);
        chk("full_ovf", 32'(Overflow), 32'd1);
        chk("full_rise", 32'(RiseCount), 32'd3);
        chk("full_fall", 32'(FallCount), 32'd2);
        chk("hold_kind", 32'(EvKind), 32'd1);
        chk("hold_time", 32'(EvTime), 32'd6);

        exp_kind[0] = 2'b01; exp_time[0] = 16'd6;
        exp_kind[1] = 2'b10; exp_time[1] = 16'd10;
        exp_kind[2] = 2'b01; exp_time[2] = 16'd14;
        exp_kind[3] = 2'b10; exp_time[3] = 16'd18;
        EvReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_kind", 32'(EvKind), 32'(exp_kind[i]));
            chk("drain_time", 32'(EvTime), 32'(exp_time[i]));
            cyc(1);
        end
        chk("drain_empty", 32'(EvValid), 32'd0);
        chk("ovf_sticky", 32'(Overflow), 32'd1);
        EvReady = 1'b0;
        ClearOvf = 1'b1;
        cyc(1);
        ClearOvf = 1'b0;
        chk("ovf_clear", 32'(Overflow), 32'd0);

        // Full FIFO: push and pop on the same edge
        Sig = 1'b0;
        cyc(4);
        Sig = 1'b1;
        cyc(4);
        Sig = 1'b0;
        cyc(4);
        Sig = 1'b1;
        cyc(4);
        Sig = 1'b0;
        cyc(2);
        EvReady = 1'b1;
        cyc(1);
        EvReady = 1'b0;
        chk("pp_ovf", 32'(Overflow), 32'd0);
        chk("pp_kind", 32'(EvKind), 32'd1);
        chk("pp_time", 32'(EvTime), 32'd35);
        chk("pp_rise", 32'(RiseCount), 32'd5);
        chk("pp_fall", 32'(FallCount), 32'd5);
        exp_kind[0] = 2'b01; exp_time[0] = 16'd35;
        exp_kind[1] = 2'b10; exp_time[1] = 16'd39;
        exp_kind[2] = 2'b01; exp_time[2] = 16'd43;
        exp_kind[3] = 2'b10; exp_time[3] = 16'd47;
        EvReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_valid", 32'(EvValid), 32'd1);
            chk("pp_dkind", 32'(EvKind), 32'(exp_kind[i]));
            chk("pp_dtime", 32'(EvTime), 32'(exp_time[i]));
            cyc(1);
        end
        chk("pp_empty", 32'(EvValid), 32'd0);

        // Enable low while Sig rises, then re-enable
        Enable = 1'b0;
        Sig = 1'b1;
        cyc(6);
        Enable = 1'b1;
        cyc(6);
        chk("en_valid", 32'(EvValid), 32'd0);
        chk("en_rise", 32'(RiseCount), 32'd5);

        // Reset with a queued record
        EvReady = 1'b0;
        Sig = 1'b0;
        cyc(4);
        chk("mid_queued", 32'(EvValid), 32'd1);
        chk("mid_fall", 32'(FallCount), 32'd6);
        Reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(EvValid), 32'd0);
        chk("mid_rst_fall", 32'(FallCount), 32'd0);
        chk("mid_rst_time", 32'(EvTime), 32'd0);
        cyc(1);
        Reset = 1'b0;
        cyc(5);
        chk("mid_after", 32'(EvValid), 32'd0);

        // Narrow instance: saturation and timestamp wrap
        s_rst = 1'b0;
        cyc(2);
        s_sig = 1'b1;
        cyc(4);
        s_sig = 1'b0;
        cyc(4);
        s_sig = 1'b1;
        cyc(3);
        chk("sat_kind12", 32'(s_kind), 32'd1);
        chk("sat_time12", 32'(s_time), 32'd12);
        cyc(1);
        s_sig = 1'b0;
        cyc(3);
        chk("wrap_valid", 32'(s_valid), 32'd1);
        chk("wrap_kind", 32'(s_kind), 32'd2);
        chk("wrap_time", 32'(s_time), 32'd0);
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            s_sig = ~s_sig;
            cyc(4);
        end
        chk("sat_rise", 32'(s_rise), 32'd3);
        chk("sat_fall", 32'(s_fall), 32'd3);
        chk("sat_ovf", 32'(s_ovf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
